winograd_tile_buffer: RTL and testbench
=======================================

Name: winograd_tile_buffer

Overview:
Streaming line buffer directly upstream of the winograd F(2x2,3x3) compute block. It accepts a row-major 8-bit feature map one pixel per handshake. It emits overlapping 4x4 input tiles at stride 2 in both dimensions, which is exactly the tiling each winograd pass needs to produce one 2x2 output block. The tile bus flattens the 16 pixels in the order winograd consumes them as inp10..inp43.

Parameters:
IMG_W, 8, image width in pixels; even, >= 4
IMG_H, 8, image height in pixels; even, >= 4

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
pix_i  input  8  input pixel
pix_valid_i  input  1  pix_i valid
pix_sof_i  input  1  marks the first pixel of a frame; qualified by pix_valid_i
pix_ready_o  output  1  block accepts pix_i this cycle
tile_o  output  128  tile; byte 4*i+j (bits 8*(4*i+j)+:8) = tile row i, col j (i,j in 0..3) -> winograd inp(i+1)(j)
tile_valid_o  output  1  tile_o valid
tile_ready_i  input  1  downstream accepts tile
tile_row_o  output  8  tile band index (output row pair)
tile_col_o  output  8  tile column index (output column pair)
frame_done_o  output  1  one-cycle pulse when the last tile of a frame is accepted

Behaviour:
- Storage: 4 row buffers x IMG_W bytes, used circularly.
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset:
  - state = FILL; row/col counters, band and tile counters = 0.
  - pix_ready_o = 0 during rst, 1 on the first cycle after.
  - tile_valid_o = 0, frame_done_o = 0, tile_o = 0, tile_row_o = tile_col_o = 0.
  - Buffer contents are not cleared.
- Pixel accept: pix_valid_i & pix_ready_o. The pixel is written at (wr_row mod 4, wr_col). wr_col wraps IMG_W-1 -> 0 and increments wr_row.
- State FILL: pix_ready_o = 1.
  - Band 0 needs rows 0..3. Band b > 0 needs 2 new rows (2b+2, 2b+3).
  - When the last pixel of the required rows is accepted -> EMIT.
  - tile_valid_o rises the next cycle (1-cycle latency).
- State EMIT: pix_ready_o = 0.
  - Tiles for columns c = 0, 2, ..., IMG_W-4, i.e. (IMG_W-2)/2 tiles per band.
  - tile_col_o = c/2, tile_row_o = b.
  - Tile rows are the buffered rows 2b..2b+3 in ascending image order, independent of the circular slot.
  - tile_o is registered and stable while tile_valid_o & !tile_ready_i.
  - On handshake: advance c. A back-to-back tile is valid the following cycle (one tile per cycle when tile_ready_i is held high).
  - After the last tile of a band:
    - if b < (IMG_H-2)/2 - 1: b++, -> FILL;
    - else: frame_done_o pulses in the same cycle as that handshake, counters reset, -> FILL for the next frame.
- Frame: (IMG_H-2)/2 bands x (IMG_W-2)/2 tiles. IMG_W=IMG_H=8 gives 3x3 = 9 tiles.
- pix_sof_i on an accepted pixel while wr_row != 0 or wr_col != 0 (mid-frame resync):
  - discard the partial frame;
  - the pixel becomes row 0, col 0;
  - band = 0, state FILL.
  - SOF is honoured only in FILL, since pixels are never accepted in EMIT.
  - pix_sof_i on an expected row 0, col 0 pixel is a no-op.
- pix_valid_i while pix_ready_o = 0: ignored. The source must hold it.
- rst mid-EMIT: tile_valid_o drops the next cycle. The partial frame is lost.
- Arithmetic: pure data movement, no pixel modification. Counters sized to ceil(log2) of their ranges. tile_row_o/tile_col_o are zero-extended.

Optional Feature:
TILE_STATS_EN
- Defined: adds output port tile_count_o [15:0].
  - Counts accepted tiles since rst and wraps at 16'hFFFF -> 0.
  - Not cleared by SOF resync.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=8, pixel value = 8*row+col, tile_ready_i=1 -> 9 tiles. Tile (0,0) bytes 0..15 = 0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27. Tile (2,2) byte0 = 36, byte15 = 63. frame_done_o pulses once with the 9th handshake.
- Same frame, tile_ready_i low 3 cycles on the first tile -> tile_valid_o held, tile_o stable = tile (0,0), pix_ready_o = 0 throughout. The accept then occurs and tile (0,1) follows, byte0 = 2.
- Band transition -> after the 3rd tile of band 0, pix_ready_o = 1. Exactly 16 pixels (rows 4,5) are accepted before tile (1,0) appears, with byte0 = 16 and byte15 = 43.
- SOF resync: 20 pixels, then pix_sof_i with value 100, then a fresh frame with offset 100 (byte0 of the resync pixel = 100). First tile byte0 = 100, byte5 = 109, and no tile is emitted from the discarded data.
- rst asserted for 1 cycle during EMIT of tile (1,1) -> next cycle tile_valid_o = 0 and pix_ready_o = 1. A full new frame yields 9 correct tiles.
- TILE_STATS_EN defined, two back-to-back 8x8 frames -> tile_count_o = 18 and frame_done_o pulses twice.

Source files
------------

// File: rtl/winograd_tile_buffer.sv
// Four-row circular line buffer that turns a row-major 8-bit pixel stream into
// overlapping 4x4 stride-2 tiles for a winograd F(2x2,3x3) stage. Optional macro: TILE_STATS_EN.
module winograd_tile_buffer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_i,
  input  logic         pix_valid_i,
  input  logic         pix_sof_i,
  output logic         pix_ready_o,
  output logic [127:0] tile_o,
  output logic         tile_valid_o,
  input  logic         tile_ready_i,
  output logic [7:0]   tile_row_o,
  output logic [7:0]   tile_col_o,
`ifdef TILE_STATS_EN
  output logic [15:0]  tile_count_o,
`endif
  output logic         frame_done_o
);

  localparam int NB = (IMG_H - 2) / 2;
  localparam int NT = (IMG_W - 2) / 2;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Handshakes: a pixel moves when pix_valid_i & pix_ready_o at a rising edge,
  // a tile moves when tile_valid_o & tile_ready_i; payloads hold until accepted.
  typedef enum logic {FILL, EMIT} state_t;
  state_t state;

  logic [7:0]    mem [4][IMG_W];
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [BW-1:0] band;
  logic [TW-1:0] tcol;
  logic [127:0]  tile_q;
  logic          tile_valid_q;

  logic          accept, resync, fill_done, hs, last_col, last_band;
  logic [1:0]    w_slot;
  logic [CW-1:0] w_col;
  logic [TW-1:0] ld_col;
  logic [127:0]  gather;
  logic [1:0]    g_slot;
  logic [CW-1:0] g_col;
  logic [7:0]    g_pix;

  assign pix_ready_o  = (state == FILL) && !rst;
  assign accept       = pix_valid_i && pix_ready_o;
  assign resync       = accept && pix_sof_i && ((wr_row != '0) || (wr_col != '0));
  assign w_slot       = resync ? 2'd0 : wr_row[1:0];
  assign w_col        = resync ? '0 : wr_col;
  assign fill_done    = accept && !resync && (int'(wr_col) == IMG_W - 1)
                        && (int'(wr_row) == 2 * int'(band) + 3);
  assign hs           = tile_valid_q && tile_ready_i;
  assign last_col     = (int'(tcol) == NT - 1);
  assign last_band    = (int'(band) == NB - 1);
  assign frame_done_o = hs && last_col && last_band;
  assign tile_o       = tile_q;
  assign tile_valid_o = tile_valid_q;
  assign ld_col       = (state == FILL) ? '0 : tcol + 1'b1;

  // The pixel written this cycle is forwarded so the first tile can load on
  // the same edge that completes the band.
  always_comb begin
    gather = '0;
    g_slot = '0;
    g_col  = '0;
    g_pix  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        g_slot = 2'(2 * int'(band) + i);
        g_col  = CW'(2 * int'(ld_col) + j);
        g_pix  = mem[g_slot][g_col];
        if (accept && (g_slot == w_slot) && (g_col == w_col)) g_pix = pix_i;
        gather[8*(4*i+j) +: 8] = g_pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[w_slot][w_col] <= pix_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wr_row       <= '0;
      wr_col       <= '0;
      band         <= '0;
      tcol         <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      tile_row_o   <= '0;
      tile_col_o   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (resync) begin
            wr_row <= '0;
            wr_col <= CW'(1);
            band   <= '0;
          end else if (accept) begin
            if (int'(wr_col) == IMG_W - 1) begin
              wr_col <= '0;
              wr_row <= (int'(wr_row) == IMG_H - 1) ? '0 : wr_row + 1'b1;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
          if (fill_done) begin
            state        <= EMIT;
            tile_valid_q <= 1'b1;
            tile_q       <= gather;
            tcol         <= '0;
            tile_row_o   <= 8'(band);
            tile_col_o   <= '0;
          end
        end
        EMIT: begin
          if (hs) begin
            if (!last_col) begin
              tcol       <= tcol + 1'b1;
              tile_q     <= gather;
              tile_col_o <= 8'(ld_col);
            end else begin
              tile_valid_q <= 1'b0;
              tcol         <= '0;
              state        <= FILL;
              band         <= last_band ? '0 : band + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef TILE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) tile_count_o <= '0;
    else if (hs) tile_count_o <= tile_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_winograd_tile_buffer.sv
// Directed bench for winograd_tile_buffer at IMG_W = IMG_H = 8.
module tb_winograd_tile_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_i;
  logic         pix_valid_i;
  logic         pix_sof_i;
  logic         pix_ready_o;
  logic [127:0] tile_o;
  logic         tile_valid_o;
  logic         tile_ready_i;
  logic [7:0]   tile_row_o;
  logic [7:0]   tile_col_o;
  logic         frame_done_o;
`ifdef TILE_STATS_EN
  logic [15:0]  tile_count_o;
`endif

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  logic [127:0] last_tile;
  logic [127:0] held;

  always #5 clk = ~clk;

  winograd_tile_buffer #(.IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .rst(rst), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_sof_i(pix_sof_i), .pix_ready_o(pix_ready_o), .tile_o(tile_o),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_row_o(tile_row_o), .tile_col_o(tile_col_o),
`ifdef TILE_STATS_EN
    .tile_count_o(tile_count_o),
`endif
    .frame_done_o(frame_done_o)
  );

  always @(posedge clk) if (frame_done_o) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference tile: pixel (r,c) of a frame with offset base is base+8r+c.
  function automatic logic [127:0] exp_tile(input int base, input int b, input int c);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[8*(4*i+j) +: 8] = 8'(base + 8 * (2 * b + i) + 2 * c + j);
    return t;
  endfunction

  task automatic send_pix(input logic [7:0] v, input logic sof);
    int n;
    n = 0;
    pix_i = v;
    pix_sof_i = sof;
    pix_valid_i = 1'b1;
    while (!pix_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("pix_wait_timeout", 128'(n), 128'(0));
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
  endtask

  task automatic send_rows(input int base, input int r0, input int nrows, input logic sof);
    for (int r = r0; r < r0 + nrows; r++)
      for (int c = 0; c < 8; c++)
        send_pix(8'(base + 8 * r + c), sof && (r == r0) && (c == 0));
  endtask

  task automatic take_tile(input int base, input int b, input int c);
    int n;
    n = 0;
    tile_ready_i = 1'b1;
    #1;
    while (!tile_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("tile_wait_timeout", 128'(n), 128'(0));
    last_tile = tile_o;
    check($sformatf("tile_%0d_%0d", b, c), tile_o, exp_tile(base, b, c));
    check($sformatf("row_%0d_%0d", b, c), 128'(tile_row_o), 128'(b));
    check($sformatf("col_%0d_%0d", b, c), 128'(tile_col_o), 128'(c));
    check($sformatf("done_%0d_%0d", b, c), 128'(frame_done_o), 128'((b == 2) && (c == 2)));
    @(posedge clk); #1;
  endtask

  task automatic take_band(input int base, input int b);
    for (int c = 0; c < 3; c++) take_tile(base, b, c);
  endtask

  task automatic run_frame(input int base, input logic sof);
    send_rows(base, 0, 4, sof);
    take_band(base, 0);
    send_rows(base, 4, 2, 1'b0);
    take_band(base, 1);
    send_rows(base, 6, 2, 1'b0);
    take_band(base, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pix_i = '0;
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    tile_ready_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_pix_ready", 128'(pix_ready_o), 128'(0));
    check("rst_tile_valid", 128'(tile_valid_o), 128'(0));
    check("rst_tile", tile_o, 128'(0));
    check("rst_tile_row", 128'(tile_row_o), 128'(0));
    check("rst_tile_col", 128'(tile_col_o), 128'(0));
    check("rst_frame_done", 128'(frame_done_o), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_pix_ready", 128'(pix_ready_o), 128'(1));

    // Frame 1: streaming with tile_ready_i high
    send_rows(0, 0, 4, 1'b1);
    take_tile(0, 0, 0);
    check("tile00_literal", last_tile, 128'h1b1a1918_13121110_0b0a0908_03020100);
    take_tile(0, 0, 1);
    take_tile(0, 0, 2);
    send_rows(0, 4, 2, 1'b0);
    take_band(0, 1);
    send_rows(0, 6, 2, 1'b0);
    take_band(0, 2);
    check("tile22_byte0", 128'(last_tile[7:0]), 128'(36));
    check("tile22_byte15", 128'(last_tile[127:120]), 128'(63));
    check("frame1_done_count", 128'(fd_cnt), 128'(1));

    // Frame 2: downstream stall on the first tile, then band transition
    tile_ready_i = 1'b0;
    send_rows(0, 0, 4, 1'b0);
    check("latency_valid", 128'(tile_valid_o), 128'(1));
    held = tile_o;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 128'(tile_valid_o), 128'(1));
      check("stall_tile", tile_o, exp_tile(0, 0, 0));
      check("stall_pix_ready", 128'(pix_ready_o), 128'(0));
      @(posedge clk); #1;
    end
    check("stall_stable", tile_o, held);
    take_tile(0, 0, 0);
    take_tile(0, 0, 1);
    check("tile01_byte0", 128'(last_tile[7:0]), 128'(2));
    take_tile(0, 0, 2);
    check("band_pix_ready", 128'(pix_ready_o), 128'(1));
    check("band_tile_valid", 128'(tile_valid_o), 128'(0));
    for (int c = 0; c < 8; c++) send_pix(8'(32 + c), 1'b0);
    for (int c = 0; c < 7; c++) send_pix(8'(40 + c), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("band_15px_no_tile", 128'(tile_valid_o), 128'(0));
    send_pix(8'(47), 1'b0);
    check("band_16px_tile", 128'(tile_valid_o), 128'(1));
    take_tile(0, 1, 0);
    check("tile10_byte0", 128'(last_tile[7:0]), 128'(16));
    check("tile10_byte15", 128'(last_tile[127:120]), 128'(43));
    take_tile(0, 1, 1);
    take_tile(0, 1, 2);
    send_rows(0, 6, 2, 1'b0);
    take_band(0, 2);
    check("frame2_done_count", 128'(fd_cnt), 128'(2));

    // Frame 3: 20 pixels then a mid-frame SOF resync at offset 100
    send_rows(0, 0, 2, 1'b0);
    for (int c = 0; c < 4; c++) send_pix(8'(16 + c), 1'b0);
    check("partial_no_tile", 128'(tile_valid_o), 128'(0));
    send_rows(100, 0, 3, 1'b1);
    for (int c = 0; c < 7; c++) send_pix(8'(124 + c), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("resync_no_early_tile", 128'(tile_valid_o), 128'(0));
    send_pix(8'(131), 1'b0);
    take_tile(100, 0, 0);
    check("resync_byte0", 128'(last_tile[7:0]), 128'(100));
    check("resync_byte5", 128'(last_tile[47:40]), 128'(109));
    take_tile(100, 0, 1);
    take_tile(100, 0, 2);
    send_rows(100, 4, 2, 1'b0);
    take_band(100, 1);
    send_rows(100, 6, 2, 1'b0);
    take_band(100, 2);
    check("frame3_done_count", 128'(fd_cnt), 128'(3));

    // Frame 4: reset while tile (1,1) is presented, then two full frames
    send_rows(0, 0, 4, 1'b0);
    take_band(0, 0);
    send_rows(0, 4, 2, 1'b0);
    take_tile(0, 1, 0);
    tile_ready_i = 1'b0;
    #1;
    check("pre_rst_valid", 128'(tile_valid_o), 128'(1));
    check("pre_rst_col", 128'(tile_col_o), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 128'(tile_valid_o), 128'(0));
    check("mid_rst_pix_ready", 128'(pix_ready_o), 128'(1));
    run_frame(40, 1'b0);
    run_frame(7, 1'b1);
    check("total_done_count", 128'(fd_cnt), 128'(5));
`ifdef TILE_STATS_EN
    check("tile_count", 128'(tile_count_o), 128'(18));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
